// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4-Lite to single-port bank responder.
// Holds the FSM state encoding, arbitration priority and row-address width helper.
package axi_mem_pkg;

  localparam int unsigned ADDR_W = 32'd12;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_RESP  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_CAPT  = 3'd4,
    ST_RD_RESP  = 3'd5
  } resp_state_t;

  typedef enum logic {
    PRIO_WRITE = 1'b0,
    PRIO_READ  = 1'b1
  } prio_t;

  // Row index width once the in-row byte offset is stripped from a byte address.
  function automatic int unsigned row_addr_width(input int unsigned size);
    return ADDR_W - size;
  endfunction

endpackage

// File: rtl/axi_hold_reg.sv
// Single-entry valid/ready capture register. Accepts one beat when empty and
// holds it until the consumer clears it; ready is registered and low in reset.
module axi_hold_reg
  import axi_mem_pkg::*;
#(
  parameter int unsigned W = 32'd8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid,
  output logic         ready,
  input  logic [W-1:0] payload,
  input  logic         clr,
  output logic         full,
  output logic [W-1:0] held
);

  logic         full_r;
  logic         ready_r;
  logic         load_s;
  logic         full_nxt_s;
  logic [W-1:0] data_r;

  // Next occupancy: a clear always wins over a new load.
  always_comb begin
    load_s     = valid && ready_r;
    full_nxt_s = full_r;
    if (clr) begin
      full_nxt_s = 1'b0;
    end else if (load_s) begin
      full_nxt_s = 1'b1;
    end else begin
      full_nxt_s = full_r;
    end
  end

  // Occupancy, registered ready and captured payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r  <= 1'b0;
      ready_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else begin
      full_r  <= full_nxt_s;
      ready_r <= !full_nxt_s;
      if (load_s) begin
        data_r <= payload;
      end
    end
  end

  assign ready = ready_r;
  assign full  = full_r;
  assign held  = data_r;

endmodule

// File: rtl/axi_bank_responder.sv
// AXI4-Lite responder driving one single-port memory bank. Write and read
// requests are serialised into one-cycle bank accesses with round-robin priority.
module axi_bank_responder
  import axi_mem_pkg::*;
#(
  parameter int unsigned SIZE = 32'd7,
  localparam int unsigned DW = 32'd8 * (32'd1 << SIZE),
  localparam int unsigned SW = 32'd1 << SIZE,
  localparam int unsigned RW = row_addr_width(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          awvalid,
  output logic          awready,
  input  logic [11:0]   awaddr,
  input  logic          wvalid,
  output logic          wready,
  input  logic [DW-1:0] wdata,
  input  logic [SW-1:0] wstrb,
  output logic          bvalid,
  input  logic          bready,
  output logic [1:0]    bresp,
  input  logic          arvalid,
  output logic          arready,
  input  logic [11:0]   araddr,
  output logic          rvalid,
  input  logic          rready,
  output logic [DW-1:0] rdata,
  output logic [1:0]    rresp,
  output logic          mem_we,
  output logic [RW-1:0] mem_row_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [SW-1:0] mem_wstrb,
  input  logic [DW-1:0] mem_rdata
);

  resp_state_t   state_r, state_nxt_s;
  prio_t         prio_r, prio_nxt_s;
  logic          aw_full_s, w_full_s;
  logic [RW-1:0] aw_row_s;
  logic [DW+SW-1:0] w_held_s;
  logic          wr_issue_s, rd_issue_s;
  logic          wr_elig_s, rd_elig_s;

  logic          mem_we_r, bvalid_r, rvalid_r;
  logic [RW-1:0] mem_row_addr_r;
  logic [DW-1:0] mem_wdata_r, rdata_r;
  logic [SW-1:0] mem_wstrb_r;

  // In-row byte offsets carry no meaning for a row-wide bank.
  logic unused_offset_s;
  assign unused_offset_s = ^{awaddr[SIZE-1:0], araddr[SIZE-1:0]};

  axi_hold_reg #(.W(RW)) u_aw_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (awvalid),
    .ready   (awready),
    .payload (awaddr[11:SIZE]),
    .clr     (wr_issue_s),
    .full    (aw_full_s),
    .held    (aw_row_s)
  );

  axi_hold_reg #(.W(DW + SW)) u_w_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (wvalid),
    .ready   (wready),
    .payload ({wdata, wstrb}),
    .clr     (wr_issue_s),
    .full    (w_full_s),
    .held    (w_held_s)
  );

  assign wr_elig_s = aw_full_s && w_full_s;
  assign rd_elig_s = arvalid;

  // Next-state and arbitration; priority flips to the other kind on every issue.
  always_comb begin
    state_nxt_s = state_r;
    prio_nxt_s  = prio_r;
    wr_issue_s  = 1'b0;
    rd_issue_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (wr_elig_s && (!rd_elig_s || (prio_r == PRIO_WRITE))) begin
          state_nxt_s = ST_WR_ISSUE;
          prio_nxt_s  = PRIO_READ;
          wr_issue_s  = 1'b1;
        end else if (rd_elig_s) begin
          state_nxt_s = ST_RD_ISSUE;
          prio_nxt_s  = PRIO_WRITE;
          rd_issue_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_ISSUE: state_nxt_s = ST_WR_RESP;
      ST_WR_RESP: begin
        if (bready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WR_RESP;
        end
      end
      ST_RD_ISSUE: state_nxt_s = ST_RD_CAPT;
      ST_RD_CAPT:  state_nxt_s = ST_RD_RESP;
      ST_RD_RESP: begin
        if (rready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RD_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, priority and registered bank/response outputs; strobes drop with reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      prio_r         <= PRIO_WRITE;
      mem_we_r       <= 1'b0;
      mem_wstrb_r    <= {SW{1'b0}};
      mem_wdata_r    <= {DW{1'b0}};
      mem_row_addr_r <= {RW{1'b0}};
      rdata_r        <= {DW{1'b0}};
      bvalid_r       <= 1'b0;
      rvalid_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      prio_r      <= prio_nxt_s;
      mem_we_r    <= wr_issue_s;
      mem_wstrb_r <= wr_issue_s ? w_held_s[SW-1:0] : {SW{1'b0}};
      if (wr_issue_s) begin
        mem_wdata_r    <= w_held_s[DW+SW-1:SW];
        mem_row_addr_r <= aw_row_s;
      end else if (rd_issue_s) begin
        mem_row_addr_r <= araddr[11:SIZE];
      end
      if (state_r == ST_RD_CAPT) begin
        rdata_r <= mem_rdata;
      end
      bvalid_r <= (state_nxt_s == ST_WR_RESP);
      rvalid_r <= (state_nxt_s == ST_RD_RESP);
    end
  end

  assign arready      = rd_issue_s;
  assign bvalid       = bvalid_r;
  assign bresp        = RESP_OKAY;
  assign rvalid       = rvalid_r;
  assign rdata        = rdata_r;
  assign rresp        = RESP_OKAY;
  assign mem_we       = mem_we_r;
  assign mem_row_addr = mem_row_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign mem_wstrb    = mem_wstrb_r;

endmodule
